// File: rtl/store_commit_pkg.sv
// Shared types for the store/AMO commit sequencer.
// Holds the FSM state encoding and the queue entry layout.
package store_commit_pkg;

    localparam int unsigned SC_NR_ENTRIES    = 8;
    localparam int unsigned SC_TRANS_ID_BITS = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        AMO_WAIT = 2'd2
    } commit_state_e;

    typedef struct packed {
        logic [SC_TRANS_ID_BITS-1:0] trans_id;
        logic                        is_amo;
    } commit_entry_t;

endpackage

// File: rtl/commit_id_fifo.sv
// In-order queue of accepted store/AMO IDs.
// A flush can optionally keep the head entry that is being committed.
module commit_id_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic                     keep_head_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    wr_q;
    logic [PW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;
    logic             keep;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && !full_o && !flush_i;
    // Keeping the head is pointless if it leaves the queue this same cycle.
    assign keep    = keep_head_i && !do_pop && (cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_pop) begin
                rd_q <= rd_q + PW'(1);
            end
            if (flush_i) begin
                wr_q  <= rd_q + PW'(do_pop || keep);
                cnt_q <= (PW+1)'(keep);
            end else begin
                if (do_push) begin
                    wr_q <= wr_q + PW'(1);
                end
                cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_q] <= data_i;
        end
    end

    assign head_o  = mem[rd_q];
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/store_commit_ctrl.sv
// Commit sequencer between the commit stage and the store unit.
// Matches commit requests against the oldest accepted store/AMO.
module store_commit_ctrl
    import store_commit_pkg::*;
#(
    parameter int unsigned NR_ENTRIES    = SC_NR_ENTRIES,
    parameter int unsigned TRANS_ID_BITS = SC_TRANS_ID_BITS
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          issue_valid_i,
    input  logic [TRANS_ID_BITS-1:0]      issue_trans_id_i,
    input  logic                          issue_is_amo_i,
    output logic                          issue_ready_o,
    input  logic                          cm_valid_i,
    input  logic [TRANS_ID_BITS-1:0]      cm_trans_id_i,
    output logic                          cm_ack_o,
    output logic                          cm_error_o,
    output logic                          su_commit_o,
    input  logic                          su_commit_ready_i,
    output logic                          su_amo_valid_commit_o,
    input  logic                          amo_ack_i,
    output logic [$clog2(NR_ENTRIES):0]   pending_cnt_o,
    output logic                          idle_o
);

    commit_state_e                   state_q;
    commit_state_e                   state_d;
    commit_entry_t                   head;
    commit_entry_t                   issue_entry;
    logic                            empty;
    logic                            full;
    logic                            pop;
    logic                            req;
    logic                            id_match;
    logic                            err_q;
    logic [$clog2(NR_ENTRIES):0]     count;

    assign issue_entry = '{trans_id: issue_trans_id_i, is_amo: issue_is_amo_i};

    commit_id_fifo #(
        .DEPTH (NR_ENTRIES),
        .WIDTH ($bits(commit_entry_t))
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (issue_valid_i),
        .data_i      (issue_entry),
        .pop_i       (pop),
        .flush_i     (flush_i),
        .keep_head_i (state_q != IDLE),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count)
    );

    // A flush in IDLE empties the queue, so no commit may start then.
    assign req      = (state_q == IDLE) && cm_valid_i && !empty && !flush_i;
    assign id_match = (cm_trans_id_i == head.trans_id);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req && id_match) begin
                    state_d = head.is_amo ? AMO_WAIT : COMMIT;
                end
            end
            COMMIT: begin
                if (su_commit_ready_i) begin
                    state_d = IDLE;
                end
            end
            AMO_WAIT: begin
                if (amo_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        su_commit_o           = 1'b0;
        su_amo_valid_commit_o = 1'b0;
        cm_ack_o              = 1'b0;
        unique case (state_q)
            COMMIT: begin
                su_commit_o = 1'b1;
                cm_ack_o    = su_commit_ready_i;
            end
            AMO_WAIT: begin
                su_amo_valid_commit_o = 1'b1;
                cm_ack_o              = amo_ack_i;
            end
            default: ;
        endcase
    end

    assign pop = cm_ack_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= req && !id_match;
        end
    end

    assign cm_error_o    = err_q;
    assign issue_ready_o = !full;
    assign pending_cnt_o = count;
    assign idle_o        = (state_q == IDLE) && empty;

endmodule

// File: tb/tb_store_commit_ctrl.sv
// Bench for store_commit_ctrl: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_store_commit_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       issue_valid;
    logic [2:0] issue_tid;
    logic       issue_amo;
    logic       issue_ready;
    logic       cm_valid;
    logic [2:0] cm_tid;
    logic       cm_ack;
    logic       cm_error;
    logic       su_commit;
    logic       su_ready;
    logic       su_amo;
    logic       amo_ack;
    logic [3:0] pending_cnt;
    logic       idle;

    always #5 clk = ~clk;

    store_commit_ctrl dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .flush_i               (flush),
        .issue_valid_i         (issue_valid),
        .issue_trans_id_i      (issue_tid),
        .issue_is_amo_i        (issue_amo),
        .issue_ready_o         (issue_ready),
        .cm_valid_i            (cm_valid),
        .cm_trans_id_i         (cm_tid),
        .cm_ack_o              (cm_ack),
        .cm_error_o            (cm_error),
        .su_commit_o           (su_commit),
        .su_commit_ready_i     (su_ready),
        .su_amo_valid_commit_o (su_amo),
        .amo_ack_i             (amo_ack),
        .pending_cnt_o         (pending_cnt),
        .idle_o                (idle)
    );

    typedef struct {
        logic [2:0] tid;
        bit         amo;
    } ent_t;

    ent_t q[$];
    int   inflight;
    bit   err_m;
    int   checks = 0;
    int   failures = 0;
    int   amo_hi = 0;
    int   commit_hi = 0;
    int   acks = 0;
    int   errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs with the model, then advance it.
    task automatic tick(input bit check = 1'b1);
        bit   e_ack;
        bit   start;
        int   old_inflight;
        int   n;
        ent_t e;
        #1;
        e_ack = (inflight == 1 && su_ready) || (inflight == 2 && amo_ack);
        if (check) begin
            chk("cm_ack", cm_ack, e_ack);
            chk("cm_error", cm_error, err_m);
            chk("su_commit", su_commit, inflight == 1);
            chk("su_amo", su_amo, inflight == 2);
            chk("pending", pending_cnt, q.size());
            chk("issue_ready", issue_ready, q.size() < 8);
            chk("idle", idle, inflight == 0 && q.size() == 0);
        end
        if (su_amo === 1'b1) amo_hi++;
        if (su_commit === 1'b1) commit_hi++;
        if (cm_ack === 1'b1) acks++;
        if (cm_error === 1'b1) errs++;
        if (!rst_n) begin
            q.delete();
            inflight = 0;
            err_m = 1'b0;
        end else begin
            old_inflight = inflight;
            start = inflight == 0 && cm_valid && q.size() > 0 && !flush;
            err_m = start && q[0].tid != cm_tid;
            if (e_ack) inflight = 0;
            if (start && q[0].tid == cm_tid) inflight = q[0].amo ? 2 : 1;
            if (flush) begin
                if (old_inflight != 0 && !e_ack && q.size() > 0) begin
                    e = q[0];
                    q.delete();
                    q.push_back(e);
                end else begin
                    q.delete();
                end
            end else begin
                n = q.size();
                if (e_ack) void'(q.pop_front());
                if (issue_valid && n < 8) q.push_back('{issue_tid, issue_amo});
            end
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] id, input bit amo);
        issue_valid = 1'b1;
        issue_tid   = id;
        issue_amo   = amo;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic commit(input logic [2:0] id);
        cm_valid = 1'b1;
        cm_tid   = id;
        su_ready = 1'b1;
        amo_ack  = 1'b1;
        tick();
        tick();
        cm_valid = 1'b0;
        su_ready = 1'b0;
        amo_ack  = 1'b0;
    endtask

    initial begin
        int a0, c0, k0, e0;
        rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_tid = '0;
        issue_amo = 1'b0; cm_valid = 1'b0; cm_tid = '0; su_ready = 1'b0;
        amo_ack = 1'b0;
        q.delete(); inflight = 0; err_m = 1'b0;
        @(negedge clk);
        tick(1'b0);
        tick(1'b0);
        rst_n = 1'b1;
        chk("rst_pending", pending_cnt, 0);
        chk("rst_idle", idle, 1);
        chk("rst_ready", issue_ready, 1);
        tick();

        // store commit with ready already high
        issue(3'd3, 1'b0);
        chk("t1_pending1", pending_cnt, 1);
        c0 = commit_hi; k0 = acks;
        cm_valid = 1'b1; cm_tid = 3'd3; su_ready = 1'b1;
        tick();
        chk("t1_no_early_commit", commit_hi - c0, 0);
        tick();
        cm_valid = 1'b0; su_ready = 1'b0;
        chk("t1_commit_cycles", commit_hi - c0, 1);
        chk("t1_acks", acks - k0, 1);
        chk("t1_pending0", pending_cnt, 0);

        // AMO with late response
        issue(3'd5, 1'b1);
        a0 = amo_hi; c0 = commit_hi; k0 = acks;
        cm_valid = 1'b1; cm_tid = 3'd5;
        tick();
        repeat (3) tick();
        amo_ack = 1'b1;
        tick();
        amo_ack = 1'b0; cm_valid = 1'b0;
        chk("t2_amo_cycles", amo_hi - a0, 4);
        chk("t2_no_commit", commit_hi - c0, 0);
        chk("t2_acks", acks - k0, 1);

        // mismatch errors, no pop
        issue(3'd1, 1'b0);
        issue(3'd2, 1'b0);
        e0 = errs; k0 = acks;
        cm_valid = 1'b1; cm_tid = 3'd2;
        repeat (3) tick();
        chk("t3_pending_kept", pending_cnt, 2);
        cm_tid = 3'd1;
        tick();
        su_ready = 1'b1;
        tick();
        cm_valid = 1'b0; su_ready = 1'b0;
        chk("t3_errs", errs - e0, 3);
        chk("t3_ack", acks - k0, 1);
        chk("t3_pending1", pending_cnt, 1);
        commit(3'd2);
        chk("t3_head2_done", pending_cnt, 0);

        // full queue, dropped issue, wrap-around order
        for (int i = 0; i < 8; i++) issue(3'(i), 1'b0);
        chk("t4_full_ready", issue_ready, 0);
        issue(3'd1, 1'b1);
        chk("t4_full_cnt", pending_cnt, 8);
        cm_valid = 1'b1; cm_tid = 3'd0;
        tick();
        su_ready = 1'b1; issue_valid = 1'b1; issue_tid = 3'd4; issue_amo = 1'b0;
        tick();
        issue_valid = 1'b0; su_ready = 1'b0; cm_valid = 1'b0;
        chk("t4_pop_full", pending_cnt, 7);
        cm_valid = 1'b1; cm_tid = 3'd1;
        tick();
        su_ready = 1'b1; issue_valid = 1'b1; issue_tid = 3'd6;
        tick();
        issue_valid = 1'b0; su_ready = 1'b0; cm_valid = 1'b0;
        chk("t4_push_pop", pending_cnt, 7);
        e0 = errs; k0 = acks;
        for (int i = 2; i < 8; i++) commit(3'(i));
        commit(3'd6);
        chk("t4_order_errs", errs - e0, 0);
        chk("t4_order_acks", acks - k0, 7);
        chk("t4_drained", pending_cnt, 0);

        // flush while a store is in flight
        issue(3'd4, 1'b0);
        issue(3'd5, 1'b0);
        issue(3'd6, 1'b0);
        cm_valid = 1'b1; cm_tid = 3'd4;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_keep_head", pending_cnt, 1);
        tick();
        su_ready = 1'b1;
        tick();
        su_ready = 1'b0; cm_valid = 1'b0;
        tick();
        chk("t5_idle", idle, 1);
        chk("t5_empty", pending_cnt, 0);

        // reset during AMO_WAIT
        issue(3'd2, 1'b1);
        cm_valid = 1'b1; cm_tid = 3'd2;
        tick();
        tick();
        rst_n = 1'b0; cm_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_amo_off", su_amo, 0);
        chk("t6_pending", pending_cnt, 0);
        chk("t6_idle", idle, 1);
        chk("t6_ready", issue_ready, 1);
        chk("t6_error", cm_error, 0);
        tick();

        // random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            issue_valid = ($urandom_range(1, 0) == 1);
            issue_tid   = 3'($urandom);
            issue_amo   = ($urandom_range(9, 0) < 3);
            flush       = ($urandom_range(29, 0) == 0);
            su_ready    = ($urandom_range(1, 0) == 1);
            amo_ack     = ($urandom_range(9, 0) < 4);
            if (inflight == 0) begin
                cm_valid = ($urandom_range(2, 0) != 0);
                if (q.size() > 0 && $urandom_range(3, 0) != 0) cm_tid = q[0].tid;
                else cm_tid = 3'($urandom);
            end
            tick();
        end
        issue_valid = 1'b0; flush = 1'b0; cm_valid = 1'b0;
        su_ready = 1'b0; amo_ack = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
